// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the memory-arbiter grant states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    IGNT,
    DGNT
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises instruction fetch and data access onto one RAM port; data wins ties,
// a saturating streak counter forces a fetch after STARVE_MAX data grants.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  iREN,
  input  word_t iaddr,
  output word_t iload,
  output logic  ihit,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output word_t dload,
  output logic  dhit,
  output logic  ram_ren,
  output logic  ram_wen,
  output word_t ram_addr,
  output word_t ram_store,
  input  word_t ram_load,
  input  logic  ram_ready
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  arb_state_t state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic       dreq;

  assign dreq = dREN | dWEN;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    ihit      = 1'b0;
    dhit      = 1'b0;
    iload     = '0;
    dload     = '0;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    unique case (state_q)
      IDLE: begin
        if (dreq && iREN)  state_d = (streak_q == SMAX) ? IGNT : DGNT;
        else if (dreq)     state_d = DGNT;
        else if (iREN)     state_d = IGNT;
      end
      IGNT: begin
        // A dropped enable abandons the access with RAM enables already low.
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ram_ren  = 1'b1;
          ram_addr = iaddr;
          if (ram_ready) begin
            ihit     = 1'b1;
            iload    = ram_load;
            state_d  = IDLE;
            streak_d = '0;
          end
        end
      end
      DGNT: begin
        if (!dreq) begin
          state_d = IDLE;
        end else begin
          ram_wen   = dWEN;
          ram_ren   = dREN & ~dWEN;
          ram_addr  = daddr;
          ram_store = dstore;
          if (ram_ready) begin
            dhit    = 1'b1;
            dload   = ram_load;
            state_d = IDLE;
            if (!iREN)                streak_d = '0;
            else if (streak_q != SMAX) streak_d = streak_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
